// File: rtl/float_div_rcp_pkg.sv
// Shared definitions for the E8/M23 reciprocal datapath: field layout of the
// unpacked result word, special encodings and per-result flag indices.
package float_div_rcp_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int EXT_W  = 4;
    localparam int X_W    = 1 + EXP_W + 1 + MAN_W + EXT_W;
    localparam int MANT_W = 1 + MAN_W + EXT_W;

    localparam int X_SIGN    = X_W - 1;
    localparam int X_EXP_MSB = X_W - 2;
    localparam int X_EXP_LSB = X_W - 1 - EXP_W;
    localparam int X_MNT_MSB = MANT_W - 1;

    localparam logic [31:0]      QNAN_32  = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

    typedef enum logic [1:0] {
        FLG_INX  = 2'd0,
        FLG_ZERO = 2'd1,
        FLG_INF  = 2'd2,
        FLG_NAN  = 2'd3
    } flag_idx_e;

    typedef enum logic [1:0] {
        KIND_NORM,
        KIND_NAN,
        KIND_INF,
        KIND_ZERO
    } kind_e;

endpackage

// File: rtl/float_div_rcp_rne_round.sv
// Round-to-nearest-even decision from the LSB, guard and sticky bits.
// Purely combinational; shared with the sqrt datapath.
module float_div_rcp_rne_round (
    input  logic lsb,
    input  logic guard,
    input  logic sticky,
    output logic inc,
    output logic inexact
);

    assign inc     = guard & (sticky | lsb);
    assign inexact = guard | sticky;

endmodule

// File: rtl/float_div_rcp_round_pack_pipe.sv
// Two-stage normalise / RNE-round / binary32-pack stage of the reciprocal
// datapath, globally stalled by astall, with sticky exception accumulation.
module float_div_rcp_round_pack_pipe
    import float_div_rcp_pkg::*;
(
    input  logic           aclk,
    input  logic           arst,
    input  logic           astall,
    input  logic           in_vld,
    input  logic [X_W-1:0] x,
    output logic           out_vld,
    output logic [31:0]    z,
    output logic [3:0]     z_flags,
    output logic [3:0]     sticky,
    input  logic           sticky_clr
);

    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MANT_W-1:0] in_mant;
    logic [MANT_W-2:0] norm_mant;
    logic [EXP_W-1:0] norm_exp;
    logic             rnd_inc;
    logic             rnd_inx;
    kind_e            s1_kind_d;
    logic             s1_inx_d;

    assign in_sign = x[X_SIGN];
    assign in_exp  = x[X_EXP_MSB:X_EXP_LSB];
    assign in_mant = x[X_MNT_MSB:0];

    // Hidden bit is dropped here; it is implied by the normal-path exponent.
    always_comb begin
        norm_mant = in_mant[MANT_W-2:0];
        norm_exp  = in_exp;
        if (!in_mant[MANT_W-1]) begin
            norm_mant = {in_mant[MANT_W-3:0], 1'b0};
            norm_exp  = in_exp - EXP_W'(1);
        end
    end

    float_div_rcp_rne_round u_rne (
        .lsb     (norm_mant[EXT_W]),
        .guard   (norm_mant[EXT_W-1]),
        .sticky  (|norm_mant[EXT_W-2:0]),
        .inc     (rnd_inc),
        .inexact (rnd_inx)
    );

    always_comb begin
        s1_kind_d = KIND_NORM;
        s1_inx_d  = rnd_inx;
        if (in_exp == EXP_ALL1) begin
            s1_kind_d = (|in_mant[MANT_W-2:EXT_W]) ? KIND_NAN : KIND_INF;
            s1_inx_d  = 1'b0;
        end else if (in_exp == '0) begin
            s1_kind_d = KIND_ZERO;
            s1_inx_d  = 1'b0;
        end else if (norm_exp == '0) begin
            // Normalisation underflowed into the denormal range: flush.
            s1_kind_d = KIND_ZERO;
            s1_inx_d  = 1'b1;
        end
    end

    logic             s1_vld;
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_frac;
    logic             s1_inc;
    logic             s1_inx;
    kind_e            s1_kind;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_frac <= '0;
            s1_inc  <= 1'b0;
            s1_inx  <= 1'b0;
            s1_kind <= KIND_NORM;
        end else if (!astall) begin
            s1_vld  <= in_vld;
            s1_sign <= in_sign;
            s1_exp  <= norm_exp;
            s1_frac <= norm_mant[EXT_W +: MAN_W];
            s1_inc  <= rnd_inc;
            s1_inx  <= s1_inx_d;
            s1_kind <= s1_kind_d;
        end
    end

    logic             rnd_carry;
    logic [MAN_W-1:0] rnd_frac;
    logic [EXP_W-1:0] rnd_exp;
    logic [31:0]      z_d;
    logic [3:0]       flags_d;

    // An all-ones fraction plus one wraps to zero, so the carry case needs no extra mux.
    assign {rnd_carry, rnd_frac} = {1'b0, s1_frac} + (MAN_W+1)'(s1_inc);
    assign rnd_exp = s1_exp + EXP_W'(rnd_carry);

    always_comb begin
        z_d     = {s1_sign, rnd_exp, rnd_frac};
        flags_d = '0;
        case (s1_kind)
            KIND_NAN: begin
                z_d              = QNAN_32;
                flags_d[FLG_NAN] = 1'b1;
            end
            KIND_INF: begin
                z_d              = {s1_sign, EXP_ALL1, {MAN_W{1'b0}}};
                flags_d[FLG_INF] = 1'b1;
            end
            KIND_ZERO: begin
                z_d               = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
                flags_d[FLG_ZERO] = 1'b1;
                flags_d[FLG_INX]  = s1_inx;
            end
            default: begin
                if (rnd_exp == EXP_ALL1) begin
                    z_d              = {s1_sign, EXP_ALL1, {MAN_W{1'b0}}};
                    flags_d[FLG_INF] = 1'b1;
                    flags_d[FLG_INX] = 1'b1;
                end else begin
                    flags_d[FLG_INX] = s1_inx;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            out_vld <= 1'b0;
            z       <= '0;
            z_flags <= '0;
            sticky  <= '0;
        end else if (!astall) begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                z       <= z_d;
                z_flags <= flags_d;
            end
            sticky <= (sticky_clr ? 4'h0 : sticky) | (s1_vld ? flags_d : 4'h0);
        end
    end

endmodule

// File: tb/tb_float_div_rcp_round_pack_pipe.sv
// Directed self-checking bench for the reciprocal round/pack pipeline.
module tb_float_div_rcp_round_pack_pipe;

    logic        aclk = 1'b0;
    logic        arst;
    logic        astall;
    logic        in_vld;
    logic [36:0] x;
    logic        out_vld;
    logic [31:0] z;
    logic [3:0]  z_flags;
    logic [3:0]  sticky;
    logic        sticky_clr;

    int checks = 0;
    int errors = 0;
    logic [31:0] got[$];

    float_div_rcp_round_pack_pipe dut (
        .aclk       (aclk),
        .arst       (arst),
        .astall     (astall),
        .in_vld     (in_vld),
        .x          (x),
        .out_vld    (out_vld),
        .z          (z),
        .z_flags    (z_flags),
        .sticky     (sticky),
        .sticky_clr (sticky_clr)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [36:0] xin);
        in_vld = v;
        x      = xin;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] ez,
                               input logic [3:0] ef);
        checkEq({tag, "_vld"}, 32'(out_vld), 32'(ev));
        checkEq({tag, "_z"}, z, ez);
        checkEq({tag, "_flags"}, 32'(z_flags), 32'(ef));
    endtask

    task automatic runOne(input string tag, input logic [36:0] xin, input logic [31:0] ez,
                          input logic [3:0] ef);
        applyStimulus(1'b1, xin);
        tick();
        applyStimulus(1'b0, '0);
        tick();
        checkOutput(tag, 1'b1, ez, ef);
    endtask

    function automatic logic [36:0] streamVec(input int k);
        return {1'b0, 8'h7F, 1'b1, 23'(k), 4'h0};
    endfunction

    initial begin
        arst       = 1'b1;
        astall     = 1'b0;
        sticky_clr = 1'b0;
        applyStimulus(1'b0, '0);
        #12;
        checkOutput("reset", 1'b0, 32'h0, 4'h0);
        checkEq("reset_sticky", 32'(sticky), 32'h0);
        arst = 1'b0;
        tick();

        runOne("one", {1'b0, 8'h7F, 28'h8000000}, 32'h3F800000, 4'b0000);
        runOne("tie_even", {1'b1, 8'h80, 28'h8000008}, 32'hC0000000, 4'b0001);
        runOne("round_up", {1'b0, 8'h7F, 28'h8000018}, 32'h3F800002, 4'b0001);
        runOne("shift", {1'b0, 8'h80, 28'h4000000}, 32'h3F800000, 4'b0000);
        runOne("carry", {1'b0, 8'h7E, 28'hFFFFFF8}, 32'h3F800000, 4'b0001);
        runOne("ovf", {1'b0, 8'hFE, 28'hFFFFFF8}, 32'h7F800000, 4'b0101);
        runOne("nan", {1'b1, 8'hFF, 28'h8000010}, 32'h7FC00000, 4'b1000);
        runOne("inf", {1'b0, 8'hFF, 28'h8000000}, 32'h7F800000, 4'b0100);
        runOne("zero", {1'b1, 8'h00, 28'h8123456}, 32'h80000000, 4'b0010);
        runOne("flush", {1'b0, 8'h01, 28'h4000000}, 32'h00000000, 4'b0011);

        // Sticky: clear, inf, then clear alongside an inexact result.
        applyStimulus(1'b0, '0);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checkEq("sticky_clr", 32'(sticky), 32'h0);
        applyStimulus(1'b1, {1'b0, 8'hFF, 28'h8000000});
        tick();
        applyStimulus(1'b1, {1'b1, 8'h80, 28'h8000008});
        tick();
        checkEq("sticky_inf", 32'(sticky), 32'h4);
        applyStimulus(1'b0, '0);
        sticky_clr = 1'b1;
        tick();
        checkEq("sticky_clr_inx", 32'(sticky), 32'h1);
        checkEq("sticky_clr_z", z, 32'hC0000000);
        astall = 1'b1;
        tick();
        checkEq("sticky_stall", 32'(sticky), 32'h1);
        astall     = 1'b0;
        sticky_clr = 1'b0;
        tick();

        // Stream of 8 with a 3-cycle stall in the middle.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                astall = 1'b1;
                applyStimulus(1'b1, streamVec(4));
                repeat (3) begin
                    tick();
                    checkEq("stall_vld", 32'(out_vld), 32'h1);
                    checkEq("stall_z", z, 32'h3F800002);
                end
                astall = 1'b0;
            end
            applyStimulus(1'b1, streamVec(i));
            tick();
            if (out_vld) got.push_back(z);
        end
        applyStimulus(1'b0, '0);
        repeat (2) begin
            tick();
            if (out_vld) got.push_back(z);
        end
        checkEq("stream_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            checkEq("stream_z", got[k], 32'h3F800000 | 32'(k));
        tick();

        // Asynchronous reset while a result is in flight.
        applyStimulus(1'b1, {1'b1, 8'h80, 28'h8000008});
        tick();
        tick();
        checkEq("pre_rst_sticky", 32'(sticky), 32'h1);
        #2;
        arst = 1'b1;
        #1;
        checkOutput("async_rst", 1'b0, 32'h0, 4'h0);
        checkEq("async_rst_sticky", 32'(sticky), 32'h0);
        tick();
        arst = 1'b0;
        tick();
        checkEq("post_rst_bubble", 32'(out_vld), 32'h0);
        tick();
        checkOutput("post_rst", 1'b1, 32'hC0000000, 4'b0001);
        applyStimulus(1'b0, '0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
